// File: rtl/sky_fetch_unit.sv
// sky_fetch_unit: instruction-fetch front end.
// PC + synchronous-read instruction memory feed a credit-gated fetch queue
// that presents instructions to decode over valid/ready. Redirects flush
// the queue and squash the read that is still in flight.
module sky_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 1024,
  parameter int unsigned     FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [XLEN-1:0]               out_instr,
  output logic [$clog2(FQ_DEPTH):0]     fq_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned QW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = QW + 1;
  localparam logic [CW-1:0] FQ_FULL = CW'(FQ_DEPTH);

  logic [XLEN-1:0] mem [IMEM_DEPTH];
  logic [XLEN-1:0] rdata;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;

  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [XLEN-1:0] q_instr [FQ_DEPTH];
  logic [QW-1:0]   head;
  logic [QW-1:0]   tail;
  logic [CW-1:0]   count;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW-1:0] occ;

  // Handshake and credit. Occupancy counts the in-flight read as a slot
  // already taken, so a return can never land in a full queue. The sum is at
  // most FQ_DEPTH+1, which fits in CW bits, and pop implies count >= 1.
  assign pop   = out_valid & out_ready;
  assign push  = inflight & ~redirect_valid;
  assign occ   = count + CW'(inflight) - CW'(pop);
  assign issue = ~redirect_valid & (occ < FQ_FULL);

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? q_pc[head]    : '0;
  assign out_instr = out_valid ? q_instr[head] : '0;
  assign fq_count  = count;

  // Instruction memory: program-load write port plus synchronous fetch read.
  // Both use NBAs, so a same-cycle read of the written word returns old data.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
    if (issue)   rdata <= mem[pc[AW+1:2]];
  end

  // PC and in-flight tracking; a redirect reloads the PC and kills the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + XLEN'(4);
      end
    end
  end

  // Queue storage; contents are only observed through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= inflight_pc;
      q_instr[tail] <= rdata;
    end
  end

  // Queue pointers and occupancy; a redirect wins over a simultaneous pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + QW'(1);
      if (pop)  head <= head + QW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Credit gating makes a push into a full queue unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count == FQ_FULL));

endmodule

// File: tb/tb_sky_fetch_unit.sv
// tb_sky_fetch_unit: directed scenarios plus a randomized run scored against
// a stream-level model: accepted instructions must follow the current fetch
// path in PC order, each carrying the model memory word at (pc/4) mod 1024.
module tb_sky_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fq_count;

  logic [31:0] mdl_mem [1024];
  int n_checks = 0;
  int n_fail   = 0;

  sky_fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle redirect pulse.
  task automatic redirect_to(input logic [31:0] npc);
    redirect_valid = 1'b1;
    redirect_pc    = npc;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Hold reset for a cycle, release it just after an edge.
  task automatic restart(input logic rdy);
    reset_n   = 1'b0;
    out_ready = rdy;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mdl_mem[i] = 32'h1000 + i;
      imem_we    = 1'b1;
      imem_waddr = 10'(i);
      imem_wdata = 32'h1000 + i;
      tick();
    end
    imem_we = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fq_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: valid=%b count=%0d, want 0/0", out_valid, fq_count);
    end
    n_checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_outs: pc=%h instr=%h, want 0/0", out_pc, out_instr);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_edge1: valid=%b, want 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000) begin
      n_fail++; $display("FAIL reset_edge2: valid=%b pc=%h instr=%h, want 1/0/1000", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_sequential();
    restart(1'b1);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL seq_edge1: valid=%b, want 0", out_valid);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'h1000 + i) begin
        n_fail++;
        $display("FAIL seq_%0d: valid=%b pc=%h instr=%h, want 1/%h/%h", i, out_valid, out_pc, out_instr, 4 * i, 32'h1000 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    restart(1'b0);
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (fq_count !== 3'd4 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL bp_full: count=%0d valid=%b pc=%h, want 4/1/0", fq_count, out_valid, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'h1000 + i) begin
        n_fail++; $display("FAIL bp_drain_%0d: valid=%b pc=%h instr=%h, want 1/%h", i, out_valid, out_pc, out_instr, 4 * i);
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    restart(1'b0);
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (fq_count !== 3'd4) begin
      n_fail++; $display("FAIL rdf_pre: count=%0d, want 4", fq_count);
    end
    redirect_to(32'h203);
    n_checks++;
    if (fq_count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdf_flush: count=%0d valid=%b, want 0/0", fq_count, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdf_edge1: valid=%b, want 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== 32'h1080) begin
      n_fail++; $display("FAIL rdf_first: valid=%b pc=%h instr=%h, want 1/200/1080", out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_pc !== 32'h204 || out_instr !== 32'h1081) begin
      n_fail++; $display("FAIL rdf_second: pc=%h instr=%h, want 204/1081", out_pc, out_instr);
    end
  endtask

  task automatic test_redirect_pop();
    out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rdp_pre: valid=%b, want 1", out_valid);
    end
    redirect_to(32'h300);
    n_checks++;
    if (fq_count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdp_flush: count=%0d valid=%b, want 0/0", fq_count, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdp_squash: valid=%b pc=%h, want 0", out_valid, out_pc);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_instr !== 32'h10C0) begin
      n_fail++; $display("FAIL rdp_first: valid=%b pc=%h instr=%h, want 1/300/10c0", out_valid, out_pc, out_instr);
    end
    tick();
    n_checks++;
    if (out_pc !== 32'h304) begin
      n_fail++; $display("FAIL rdp_second: pc=%h, want 304", out_pc);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect_to(32'hFFC);
    tick(); tick();
    n_checks++;
    if (out_pc !== 32'hFFC || out_instr !== 32'h13FF) begin
      n_fail++; $display("FAIL wrap_ffc: pc=%h instr=%h, want ffc/13ff", out_pc, out_instr);
    end
    tick();
    n_checks++;
    if (out_pc !== 32'h1000 || out_instr !== 32'h1000) begin
      n_fail++; $display("FAIL wrap_alias: pc=%h instr=%h, want 1000/1000", out_pc, out_instr);
    end
    redirect_to(32'hFFFF_FFFC);
    tick(); tick();
    n_checks++;
    if (out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h13FF) begin
      n_fail++; $display("FAIL wrap_top: pc=%h instr=%h, want fffffffc/13ff", out_pc, out_instr);
    end
    tick();
    n_checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h1000) begin
      n_fail++; $display("FAIL wrap_zero: pc=%h instr=%h, want 0/1000", out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (fq_count === 3'd0) begin
      n_fail++; $display("FAIL ar_pre: count=%0d, want nonzero", fq_count);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || fq_count !== 3'd0 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL ar_immediate: valid=%b count=%0d pc=%h, want 0/0/0", out_valid, fq_count, out_pc);
    end
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ar_edge1: valid=%b, want 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000) begin
      n_fail++; $display("FAIL ar_restart: valid=%b pc=%h instr=%h, want 1/0/1000", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_mem_write();
    out_ready = 1'b0;
    redirect_to(32'h40);
    imem_we    = 1'b1;
    imem_waddr = 10'h10;
    imem_wdata = 32'hDEAD_BEEF;
    tick();
    imem_we = 1'b0;
    mdl_mem[10'h10] = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if (out_pc !== 32'h40 || out_instr !== 32'h1010) begin
      n_fail++; $display("FAIL mw_old: pc=%h instr=%h, want 40/1010", out_pc, out_instr);
    end
    redirect_to(32'h40);
    tick(); tick();
    n_checks++;
    if (out_pc !== 32'h40 || out_instr !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mw_new: pc=%h instr=%h, want 40/deadbeef", out_pc, out_instr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = '0;
    logic [31:0] rpc;
    int stable   = 0;
    int accepted = 0;
    for (int i = 0; i < 3000; i++) begin
      n_checks++;
      if (out_valid !== (fq_count != 3'd0) || fq_count > 3'd4) begin
        n_fail++; $display("FAIL rnd_count_%0d: valid=%b count=%0d", i, out_valid, fq_count);
      end
      if (stable >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL rnd_bubble_%0d: valid=%b, want 1", i, out_valid);
        end
      end
      if (!out_valid) begin
        n_checks++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
          n_fail++; $display("FAIL rnd_empty_%0d: pc=%h instr=%h, want 0/0", i, out_pc, out_instr);
        end
      end
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = (i == 0) || ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 1) == 1) rpc = $urandom;
      else rpc = 32'($urandom_range(0, 511)) * 4 + 32'($urandom_range(0, 3));
      redirect_pc = rpc;
      if (out_valid && out_ready && !redirect_valid) begin
        n_checks++;
        if (out_pc !== exp_pc || out_instr !== mdl_mem[exp_pc[11:2]]) begin
          n_fail++;
          $display("FAIL rnd_stream_%0d: pc=%h instr=%h, want %h/%h", i, out_pc, out_instr, exp_pc, mdl_mem[exp_pc[11:2]]);
        end
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      if (redirect_valid) begin
        exp_pc = rpc & ~32'd3;
        stable = 0;
      end else begin
        stable++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    n_checks++;
    if (accepted < 500) begin
      n_fail++; $display("FAIL rnd_progress: accepted=%0d, want >= 500", accepted);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    test_mem_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
